// File: rtl/avalon_pix_pkg.sv
// Shared types and constants for the frame scan-out fetch engine.
package avalon_pix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        REQ   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STRIDE = 2'd1;
    localparam logic [1:0] REG_WIDTH  = 2'd2;
    localparam logic [1:0] REG_HEIGHT = 2'd3;

    localparam int BURST_LIMIT = 64;

    // Burst length is the smaller of the configured maximum and what is left on the line.
    function automatic logic [6:0] burst_len(input logic [15:0] beats_left, input int burst);
        if (beats_left > 16'(burst)) begin
            return 7'(burst);
        end
        return beats_left[6:0];
    endfunction

endpackage

// File: rtl/pix_credit_counter.sv
// Saturating counter: +1 (ignored at MAX) and a multi-unit decrement (clamped at 0) per cycle.
module pix_credit_counter #(
    parameter int CW  = 9,
    parameter int MAX = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec_en,
    input  logic [CW-1:0] dec_amt,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] MAX_V = CW'(MAX);

    logic [CW-1:0] count_q, count_d;
    logic [CW:0]   sum;

    always_comb begin
        sum     = {1'b0, count_q} + {{CW{1'b0}}, (inc && (count_q != MAX_V))};
        count_d = sum[CW-1:0];
        if (dec_en) begin
            if (sum < {1'b0, dec_amt}) begin
                count_d = '0;
            end else begin
                count_d = sum[CW-1:0] - dec_amt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= MAX_V;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/avalon_pix_fetch.sv
// Frame scan-out scheduler: walks a rectangular frame and issues credit-limited
// Avalon burst reads, restarting cleanly when vsync arrives mid-frame.
module avalon_pix_fetch
    import avalon_pix_pkg::*;
#(
    parameter int BURST      = 32,
    parameter int FIFO_DEPTH = 256,
    parameter int CW         = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic [1:0]  control_address,
    input  logic        control_write,
    input  logic [31:0] control_writedata,
    output logic [31:0] master_address,
    output logic [6:0]  master_burstcount,
    output logic        master_read,
    input  logic        master_readdatavalid,
    input  logic        master_waitrequest,
    input  logic        beat_pop,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_late
);

    localparam logic [CW-1:0] DEPTH_V = CW'(FIFO_DEPTH);

    state_e      state_q, state_d;
    logic        enable_q, enable_d;
    logic [30:0] start_q, start_d;
    logic [15:0] stride_q, stride_d;
    logic [15:0] width_q, width_d;
    logic [15:0] height_q, height_d;
    logic [15:0] sh_stride_q, sh_stride_d;
    logic [15:0] sh_width_q, sh_width_d;
    logic [31:0] line_addr_q, line_addr_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] lines_left_q, lines_left_d;
    logic [15:0] beats_left_q, beats_left_d;
    logic        abort_q, abort_d;
    logic        master_read_q, master_read_d;
    logic [31:0] master_address_q, master_address_d;
    logic [6:0]  master_burstcount_q, master_burstcount_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_late_q, frame_late_d;

    logic          accept;
    logic          abort_now;
    logic [6:0]    len_c;
    logic [15:0]   beats_next;
    logic [15:0]   lines_next;
    logic [CW-1:0] credits;
    logic [CW-1:0] free_slots;
    logic [CW-1:0] outstanding;

    assign accept      = master_read_q & ~master_waitrequest;
    assign outstanding = DEPTH_V - free_slots;

    pix_credit_counter #(
        .CW (CW),
        .MAX(FIFO_DEPTH)
    ) u_credits (
        .clk    (clk),
        .reset  (reset),
        .inc    (beat_pop),
        .dec_en (accept),
        .dec_amt(CW'(master_burstcount_q)),
        .count  (credits)
    );

    // Counts slots not yet requested; outstanding beats are its complement, so a
    // stray readdatavalid at zero outstanding saturates instead of wrapping.
    pix_credit_counter #(
        .CW (CW),
        .MAX(FIFO_DEPTH)
    ) u_outstanding (
        .clk    (clk),
        .reset  (reset),
        .inc    (master_readdatavalid),
        .dec_en (accept),
        .dec_amt(CW'(master_burstcount_q)),
        .count  (free_slots)
    );

    always_comb begin
        state_d             = state_q;
        enable_d            = enable_q;
        start_d             = start_q;
        stride_d            = stride_q;
        width_d             = width_q;
        height_d            = height_q;
        sh_stride_d         = sh_stride_q;
        sh_width_d          = sh_width_q;
        line_addr_d         = line_addr_q;
        addr_d              = addr_q;
        lines_left_d        = lines_left_q;
        beats_left_d        = beats_left_q;
        master_read_d       = master_read_q;
        master_address_d    = master_address_q;
        master_burstcount_d = master_burstcount_q;
        frame_done_d        = 1'b0;
        frame_late_d        = vsync & busy_q;
        abort_now           = abort_q | (vsync & busy_q);
        abort_d             = abort_now;
        len_c               = burst_len(beats_left_q, BURST);
        beats_next          = beats_left_q;
        lines_next          = lines_left_q;

        if (control_write) begin
            case (control_address)
                REG_CTRL: begin
                    enable_d = control_writedata[0];
                    start_d  = control_writedata[31:1];
                end
                REG_STRIDE: stride_d = control_writedata[15:0];
                REG_WIDTH:  width_d  = control_writedata[15:0];
                default:    height_d = control_writedata[15:0];
            endcase
        end

        case (state_q)
            IDLE: begin
                if (vsync && enable_q) begin
                    sh_stride_d  = stride_q;
                    sh_width_d   = width_q;
                    line_addr_d  = {1'b0, start_q};
                    addr_d       = {1'b0, start_q};
                    lines_left_d = height_q;
                    beats_left_d = width_q;
                    state_d      = (width_q == '0 || height_q == '0) ? DRAIN : CALC;
                end
            end
            CALC: begin
                if (abort_now) begin
                    state_d = DRAIN;
                end else if (credits >= CW'(len_c)) begin
                    state_d             = REQ;
                    master_read_d       = 1'b1;
                    master_address_d    = addr_q;
                    master_burstcount_d = len_c;
                end
            end
            REQ: begin
                if (accept) begin
                    master_read_d = 1'b0;
                    addr_d        = addr_q + 32'(master_burstcount_q);
                    beats_next    = beats_left_q - 16'(master_burstcount_q);
                    if (beats_next == '0) begin
                        lines_next  = lines_left_q - 16'd1;
                        line_addr_d = line_addr_q + 32'(sh_stride_q);
                        addr_d      = line_addr_q + 32'(sh_stride_q);
                        beats_next  = sh_width_q;
                    end
                    beats_left_d = beats_next;
                    lines_left_d = lines_next;
                    state_d      = (lines_next == '0 || abort_now) ? DRAIN : CALC;
                end
            end
            default: begin
                if (outstanding == '0) begin
                    if (abort_now) begin
                        abort_d      = 1'b0;
                        sh_stride_d  = stride_q;
                        sh_width_d   = width_q;
                        line_addr_d  = {1'b0, start_q};
                        addr_d       = {1'b0, start_q};
                        lines_left_d = height_q;
                        beats_left_d = width_q;
                        // An empty reloaded frame still finishes through DRAIN with a frame_done.
                        state_d      = (width_q == '0 || height_q == '0) ? DRAIN : CALC;
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q             <= IDLE;
            enable_q            <= 1'b0;
            start_q             <= '0;
            stride_q            <= '0;
            width_q             <= '0;
            height_q            <= '0;
            sh_stride_q         <= '0;
            sh_width_q          <= '0;
            line_addr_q         <= '0;
            addr_q              <= '0;
            lines_left_q        <= '0;
            beats_left_q        <= '0;
            abort_q             <= 1'b0;
            master_read_q       <= 1'b0;
            master_address_q    <= '0;
            master_burstcount_q <= '0;
            busy_q              <= 1'b0;
            frame_done_q        <= 1'b0;
            frame_late_q        <= 1'b0;
        end else begin
            state_q             <= state_d;
            enable_q            <= enable_d;
            start_q             <= start_d;
            stride_q            <= stride_d;
            width_q             <= width_d;
            height_q            <= height_d;
            sh_stride_q         <= sh_stride_d;
            sh_width_q          <= sh_width_d;
            line_addr_q         <= line_addr_d;
            addr_q              <= addr_d;
            lines_left_q        <= lines_left_d;
            beats_left_q        <= beats_left_d;
            abort_q             <= abort_d;
            master_read_q       <= master_read_d;
            master_address_q    <= master_address_d;
            master_burstcount_q <= master_burstcount_d;
            busy_q              <= busy_d;
            frame_done_q        <= frame_done_d;
            frame_late_q        <= frame_late_d;
        end
    end

    assign master_read       = master_read_q;
    assign master_address    = master_address_q;
    assign master_burstcount = master_burstcount_q;
    assign busy              = busy_q;
    assign frame_done        = frame_done_q;
    assign frame_late        = frame_late_q;

endmodule

// File: doc/avalon_pix_fetch.md
Name: avalon_pix_fetch

Overview:
- Frame scan-out scheduler driving the Avalon read slave of the RGB pixel-expansion bridge. Each 128-bit beat carries 4 pixels.
- Walks a rectangular frame line by line and issues burst reads sized to the remaining line length and to free space in the downstream pixel FIFO.
- Tracks outstanding beats and sequences frame start and stop from the video timing's vsync.

Parameters:
- BURST, 32, maximum beats per burst (1..64).
- FIFO_DEPTH, 256, beats of downstream FIFO space; sets the initial credit.
- CW, 9, credit/outstanding counter width; must hold FIFO_DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vsync  in  1  single-cycle frame-start pulse, synchronous to clk.
- control_address  in  2  register select.
- control_write  in  1  register write strobe.
- control_writedata  in  32  register write data.
- master_address  out  32  beat index on the bridge slave.
- master_burstcount  out  7  beats in the current burst.
- master_read  out  1  read request.
- master_readdatavalid  in  1  one beat returned.
- master_waitrequest  in  1  bridge stall.
- beat_pop  in  1  downstream consumed one beat from the FIFO.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a frame has fully drained.
- frame_late  out  1  one-cycle pulse when vsync arrives while not IDLE.

Behaviour:
- Register map (write-only, live copies):
  - addr 0: bit0 enable.
  - addr 1: stride in beats [15:0].
  - addr 2: width in beats [15:0].
  - addr 3: height in lines [15:0].
  - addr 0 also holds the start beat index: writedata[31:1] is the start index when bit0 is written. The upper bits are stored, the enable bit is separate.
- Shadowing: live copies are written any cycle. They are copied into shadow registers only when the FSM leaves IDLE. A mid-frame write never changes the current frame.
- Reset values: master_read=0, master_address=0, master_burstcount=0, busy=0, frame_done=0, frame_late=0, credits=FIFO_DEPTH, outstanding=0, all registers 0, state IDLE.
- FSM states: IDLE, CALC, REQ, DRAIN.
- IDLE:
  - On vsync with enable=1: load shadows; line_addr = addr = start; lines_left = height; beats_left = width.
  - If width==0 or height==0, go to DRAIN. Otherwise go to CALC.
  - vsync with enable=0 is ignored.
- CALC:
  - len = min(BURST, beats_left).
  - If credits >= len, go to REQ next cycle with master_read=1, master_address=addr, master_burstcount=len. Otherwise stay in CALC with master_read=0.
- REQ:
  - master_read and all master outputs are held stable while master_waitrequest=1.
  - Acceptance is master_read & !master_waitrequest. On acceptance:
    - master_read drops the next cycle;
    - credits -= len; outstanding += len; addr += len; beats_left -= len.
  - If beats_left becomes 0: lines_left -= 1; line_addr += stride; addr = line_addr + stride; beats_left = width.
  - If lines_left becomes 0, or an abort is pending, go to DRAIN. Otherwise go to CALC.
  - Throughput: at most one burst per 2 cycles (CALC then REQ).
- DRAIN:
  - Wait until outstanding==0.
  - Then pulse frame_done and go to IDLE. If an abort is pending, instead reload shadows and go straight to CALC; the abort flag clears.
- Counters, updated every cycle:
  - credits += beat_pop, minus len on acceptance. Both may occur in the same cycle.
  - beat_pop when credits==FIFO_DEPTH is ignored (saturate).
  - outstanding -= master_readdatavalid, plus len on acceptance, same cycle allowed.
  - master_readdatavalid when outstanding==0 is ignored.
- vsync while busy:
  - Pulse frame_late and set the abort flag.
  - An accepted burst is never cancelled. No new burst is issued after the abort flag sets.
  - A request already presented (master_read=1 under waitrequest) completes before the FSM goes to DRAIN.
- Address arithmetic is 32-bit modulo 2^32 and wraps silently.
- Asynchronous reset mid-burst clears everything immediately, including master_read. In-flight beats returned after reset are ignored (outstanding is 0 and saturates).

Decomposition:
- Package avalon_pix_pkg holds:
  - state encoding enum (IDLE, CALC, REQ, DRAIN);
  - register address constants (REG_CTRL=0, REG_STRIDE=1, REG_WIDTH=2, REG_HEIGHT=3);
  - the BURST maximum limit constant 64.
- One natural sub-module, pix_credit_counter: saturating up/down counter with multi-unit decrement and single-unit increment. Instantiated twice, for credits and outstanding.

Test Plan:
- Setup start=0x1000, stride=200, width=100, height=2, enable=1, BURST=32, no waitrequest, immediate readdatavalid and beat_pop; then vsync:
  - bursts issued: (0x1000,32), (0x1020,32), (0x1040,32), (0x1060,4), (0x10C8,32), ..., (0x1128,4);
  - frame_done pulses once, after the 200th returned beat.
- FIFO_DEPTH=64, no beat_pop, width=100, height=1:
  - exactly 2 bursts of 32 issued, then the FSM stalls in CALC with busy=1;
  - after 32 beat_pop pulses, the third burst (addr+64, len 32) issues.
- master_waitrequest held high 5 cycles on the first request:
  - address and burstcount stay stable for all 5 cycles;
  - credits decrement exactly once, on the release cycle.
- Second vsync mid-frame after burst 2 is accepted:
  - frame_late pulses, no third burst;
  - after 64 readdatavalid, the FSM restarts at the start address with the newly written width;
  - no frame_done for the aborted frame.
- height=0 with vsync:
  - no master_read ever;
  - frame_done pulses 2 cycles after vsync.
- reset asserted while master_read=1 under waitrequest:
  - master_read=0 and busy=0 in the same cycle;
  - after release, credits=FIFO_DEPTH and the FSM stays in IDLE until the next vsync.
